// File: rtl/pio_poll_pkg.sv
// -----------------------------------------------------------------------------
// pio_poll_pkg
// Shared definitions for the PIO poll master: FSM state encoding, the two
// input-PIO register addresses it touches, and a helper that sizes the poll
// interval counter.
// -----------------------------------------------------------------------------
package pio_poll_pkg;

  // Poll master FSM states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EC_ADDR   = 3'd1,
    ST_EC_SAMPLE = 3'd2,
    ST_EC_CLEAR  = 3'd3,
    ST_LV_ADDR   = 3'd4,
    ST_LV_SAMPLE = 3'd5
  } pio_poll_state_e;

  // Input-PIO slave word addresses.
  localparam logic [1:0] ADDR_DATA = 2'd0;  // live input level
  localparam logic [1:0] ADDR_EDGE = 2'd3;  // edge-capture register, write clears

  localparam int unsigned AVM_DATA_W = 32;

  // Bits needed to hold period-1 (at least one bit).
  function automatic int unsigned timer_width(input int unsigned period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage : pio_poll_pkg

// File: rtl/pio_poll_timer.sv
// -----------------------------------------------------------------------------
// pio_poll_timer
// Poll interval down-counter. Loads POLL_PERIOD-1 on load, decrements while
// run is high, and holds once it reaches zero.
//
// Ports:
//   clk     in   rising-edge clock
//   reset_n in   asynchronous active-low reset (counter returns to the reload value)
//   load    in   reload POLL_PERIOD-1 at the next edge (has priority over run)
//   run     in   decrement at the next edge while non-zero
//   zero    out  counter is currently zero
// -----------------------------------------------------------------------------
module pio_poll_timer
  import pio_poll_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 1000,
  parameter int unsigned TIMER_W     = timer_width(POLL_PERIOD)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  output logic zero
);

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(POLL_PERIOD - 1);
  localparam logic [TIMER_W-1:0] ONE    = TIMER_W'(1);

  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (load) begin
      timer_d = RELOAD;
    end else if (run && (timer_q != '0)) begin
      timer_d = timer_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= RELOAD;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign zero = (timer_q == '0);

endmodule : pio_poll_timer

// File: rtl/pio_poll_master.sv
// -----------------------------------------------------------------------------
// pio_poll_master
// Avalon-MM master that periodically polls an input-PIO slave. Each poll reads
// the edge-capture register; if an edge was captured it clears the register
// with a write of zero, pulses event_pulse and bumps a saturating counter. It
// then reads the data register to refresh the reported input level.
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   enable         in   permits new polls (an active poll always completes)
//   count_clr      in   synchronous clear of event_count (wins over increment)
//   avm_address    out  slave word address
//   avm_chipselect out  slave select
//   avm_write_n    out  active-low write strobe
//   avm_writedata  out  write data (always zero: edge-capture clear)
//   avm_readdata   in   slave read data, registered in the slave (1 clock)
//   event_pulse    out  one-clock pulse per captured edge
//   event_count    out  saturating event count
//   level          out  last sampled input level
//   busy           out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module pio_poll_master
  import pio_poll_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  count_clr,
  output logic [1:0]            avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_write_n,
  output logic [AVM_DATA_W-1:0] avm_writedata,
  input  logic [AVM_DATA_W-1:0] avm_readdata,
  output logic                  event_pulse,
  output logic [CNT_W-1:0]      event_count,
  output logic                  level,
  output logic                  busy
);

  pio_poll_state_e state_q;
  pio_poll_state_e state_d;

  logic             timer_zero;
  logic             timer_load;
  logic             timer_run;
  logic             count_inc;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             level_q;
  logic             level_d;

  // Only bit 0 of either PIO register is meaningful here.
  logic unused_readdata_hi;
  assign unused_readdata_hi = ^avm_readdata[AVM_DATA_W-1:1];

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + CNT_W'(1);
  endfunction

  // The interval restarts when the last bus state hands back to IDLE, so IDLE
  // lasts exactly POLL_PERIOD clocks when enable stays high.
  assign timer_load = (state_q == ST_LV_SAMPLE);
  assign timer_run  = (state_q == ST_IDLE);

  pio_poll_timer #(
    .POLL_PERIOD(POLL_PERIOD)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (timer_load),
    .run    (timer_run),
    .zero   (timer_zero)
  );

  // Bus outputs decode directly from the state register so that an
  // asynchronous reset drops chipselect and busy in the same clock.
  always_comb begin
    state_d        = state_q;
    avm_address    = ADDR_DATA;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_writedata  = '0;
    event_pulse    = 1'b0;
    count_inc      = 1'b0;
    level_d        = level_q;

    case (state_q)
      ST_IDLE: begin
        if (timer_zero && enable) begin
          state_d = ST_EC_ADDR;
        end
      end

      // Present the edge-capture address; the slave registers its read data.
      ST_EC_ADDR: begin
        avm_address    = ADDR_EDGE;
        avm_chipselect = 1'b1;
        state_d        = ST_EC_SAMPLE;
      end

      ST_EC_SAMPLE: begin
        avm_address    = ADDR_EDGE;
        avm_chipselect = 1'b1;
        state_d        = avm_readdata[0] ? ST_EC_CLEAR : ST_LV_ADDR;
      end

      // Clear the capture bit and report the event in the same clock.
      ST_EC_CLEAR: begin
        avm_address    = ADDR_EDGE;
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_writedata  = '0;
        event_pulse    = 1'b1;
        count_inc      = 1'b1;
        state_d        = ST_LV_ADDR;
      end

      ST_LV_ADDR: begin
        avm_address    = ADDR_DATA;
        avm_chipselect = 1'b1;
        state_d        = ST_LV_SAMPLE;
      end

      ST_LV_SAMPLE: begin
        avm_address    = ADDR_DATA;
        avm_chipselect = 1'b1;
        level_d        = avm_readdata[0];
        state_d        = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clear takes priority over a coincident increment.
  always_comb begin
    count_d = count_q;
    if (count_clr) begin
      count_d = '0;
    end else if (count_inc) begin
      count_d = sat_inc(count_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_d;
    end
  end

  assign event_count = count_q;
  assign level       = level_q;
  assign busy        = (state_q != ST_IDLE);

endmodule : pio_poll_master

// File: tb/tb_pio_poll_master.sv
// -----------------------------------------------------------------------------
// tb_pio_poll_master
// Directed bench for pio_poll_master (POLL_PERIOD=4, CNT_W=2) connected to a
// behavioural model of the input-PIO slave with rising-edge capture.
// -----------------------------------------------------------------------------
module tb_pio_poll_master;

  localparam int unsigned P = 4;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        count_clr;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        event_pulse;
  logic [1:0]  event_count;
  logic        level;
  logic        busy;
  logic        in_port;

  int checks = 0;
  int errors = 0;

  pio_poll_master #(
    .POLL_PERIOD(P),
    .CNT_W      (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .count_clr     (count_clr),
    .avm_address   (avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write_n   (avm_write_n),
    .avm_writedata (avm_writedata),
    .avm_readdata  (avm_readdata),
    .event_pulse   (event_pulse),
    .event_count   (event_count),
    .level         (level),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input-PIO slave: two-flop synchroniser, rising-edge capture at address 3
  // cleared by any write there (clear wins), registered read data.
  logic sync1, sync2, capture;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      capture      <= 1'b0;
      avm_readdata <= 32'd0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      if (avm_chipselect && !avm_write_n && (avm_address == 2'd3)) begin
        capture <= 1'b0;
      end else if (sync1 && !sync2) begin
        capture <= 1'b1;
      end
      if (avm_address == 2'd0) begin
        avm_readdata <= {31'd0, in_port};
      end else if (avm_address == 2'd3) begin
        avm_readdata <= {31'd0, capture};
      end else begin
        avm_readdata <= 32'd0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One poll starting in the first IDLE clock, ending in the next first IDLE
  // clock. With rise set, in_port goes 0 then 1 in the first two IDLE clocks.
  task automatic run_poll(input int idle_n, input bit rise, input bit exp_ev,
                          input bit clr, input bit drop_en,
                          input logic [1:0] exp_cnt, input logic exp_lvl);
    for (int i = 0; i < idle_n; i++) begin
      if (rise && i == 0) in_port = 1'b0;
      if (rise && i == 1) in_port = 1'b1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_cs", 32'(avm_chipselect), 32'd0);
      tick();
    end
    chk("ec_addr_cs", 32'(avm_chipselect), 32'd1);
    chk("ec_addr_adr", 32'(avm_address), 32'd3);
    chk("ec_addr_wn", 32'(avm_write_n), 32'd1);
    tick();
    if (drop_en) enable = 1'b0;
    chk("ec_smp_cs", 32'(avm_chipselect), 32'd1);
    chk("ec_smp_adr", 32'(avm_address), 32'd3);
    chk("ec_smp_wn", 32'(avm_write_n), 32'd1);
    tick();
    if (exp_ev) begin
      count_clr = clr;
      chk("ec_clr_cs", 32'(avm_chipselect), 32'd1);
      chk("ec_clr_adr", 32'(avm_address), 32'd3);
      chk("ec_clr_wn", 32'(avm_write_n), 32'd0);
      chk("ec_clr_wd", avm_writedata, 32'd0);
      chk("ec_clr_pulse", 32'(event_pulse), 32'd1);
      tick();
      count_clr = 1'b0;
    end
    chk("lv_addr_cs", 32'(avm_chipselect), 32'd1);
    chk("lv_addr_adr", 32'(avm_address), 32'd0);
    chk("lv_addr_wn", 32'(avm_write_n), 32'd1);
    chk("lv_addr_pulse", 32'(event_pulse), 32'd0);
    tick();
    chk("lv_smp_cs", 32'(avm_chipselect), 32'd1);
    chk("lv_smp_adr", 32'(avm_address), 32'd0);
    tick();
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_cs", 32'(avm_chipselect), 32'd0);
    chk("end_count", 32'(event_count), 32'(exp_cnt));
    chk("end_level", 32'(level), 32'(exp_lvl));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    count_clr = 1'b0;
    in_port   = 1'b0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_cs", 32'(avm_chipselect), 32'd0);
    chk("rst_wn", 32'(avm_write_n), 32'd1);
    chk("rst_adr", 32'(avm_address), 32'd0);
    chk("rst_wd", avm_writedata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulse", 32'(event_pulse), 32'd0);
    chk("rst_count", 32'(event_count), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    reset_n = 1'b1;

    // Idle polling every P+4 clocks, no events
    run_poll(P, 0, 0, 0, 0, 2'd0, 1'b0);
    run_poll(P, 0, 0, 0, 0, 2'd0, 1'b0);
    // Single rising edge: one clear write, one pulse, count 1, level 1
    run_poll(P, 1, 1, 0, 0, 2'd1, 1'b1);
    run_poll(P, 0, 0, 0, 0, 2'd1, 1'b1);

    // Three rising edges inside one interval (polls held off by enable=0)
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_port = (i % 2 == 1);
      tick();
    end
    for (int i = 0; i < 4; i++) tick();
    chk("hold_busy", 32'(busy), 32'd0);
    chk("hold_cs", 32'(avm_chipselect), 32'd0);
    enable = 1'b1;
    run_poll(1, 0, 1, 0, 0, 2'd2, 1'b1);

    // Saturation: events 3, 4, 5 leave the 2-bit count at 3
    run_poll(P, 1, 1, 0, 0, 2'd3, 1'b1);
    run_poll(P, 1, 1, 0, 0, 2'd3, 1'b1);
    run_poll(P, 1, 1, 0, 0, 2'd3, 1'b1);

    // Reset asserted during EC_CLEAR
    in_port = 1'b0; tick();
    in_port = 1'b1; tick();
    tick(); tick();
    tick(); tick();
    chk("pre_rst_wn", 32'(avm_write_n), 32'd0);
    reset_n = 1'b0;
    in_port = 1'b0;
    #1;
    chk("midrst_cs", 32'(avm_chipselect), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wn", 32'(avm_write_n), 32'd1);
    chk("midrst_pulse", 32'(event_pulse), 32'd0);
    chk("midrst_count", 32'(event_count), 32'd0);
    chk("midrst_adr", 32'(avm_address), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    // First poll P clocks after release
    run_poll(P, 0, 0, 0, 0, 2'd0, 1'b0);

    // Count 1, 2, 3 then clear coinciding with the 4th event
    run_poll(P, 1, 1, 0, 0, 2'd1, 1'b1);
    run_poll(P, 1, 1, 0, 0, 2'd2, 1'b1);
    run_poll(P, 1, 1, 0, 0, 2'd3, 1'b1);
    run_poll(P, 1, 1, 1, 0, 2'd0, 1'b1);

    // enable dropped during EC_SAMPLE: poll completes, then no further polls
    run_poll(P, 1, 1, 0, 1, 2'd1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      chk("noen_busy", 32'(busy), 32'd0);
      tick();
    end
    enable = 1'b1;
    run_poll(1, 0, 0, 0, 0, 2'd1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pio_poll_master

// File: doc/pio_poll_master.md
PIO_POLL_MASTER -- requirements
Module: pio_poll_master

Interface
REQ-001 SHALL have parameter POLL_PERIOD, default 1000; clocks from entering IDLE to the next poll, legal range 4..2^20.
REQ-002 SHALL have parameter CNT_W, default 16; width of event_count.
REQ-003 SHALL have port clk, input, 1; rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1; reset, asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1; permits new polls.
REQ-006 SHALL have port count_clr, input, 1; synchronous clear of event_count.
REQ-007 SHALL have port avm_address, output, 2; Avalon-MM word address to the input-PIO slave.
REQ-008 SHALL have port avm_chipselect, output, 1; slave select.
REQ-009 SHALL have port avm_write_n, output, 1; active-low write strobe.
REQ-010 SHALL have port avm_writedata, output, 32; write data.
REQ-011 SHALL have port avm_readdata, input, 32; slave read data, registered in the slave, valid one clock after the address is presented.
REQ-012 SHALL have port event_pulse, output, 1; one-clock pulse per detected captured edge.
REQ-013 SHALL have port event_count, output, CNT_W; saturating count of events.
REQ-014 SHALL have port level, output, 1; last sampled input level (slave address 0, bit 0).
REQ-015 SHALL have port busy, output, 1; high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, EC_ADDR, EC_SAMPLE, EC_CLEAR, LV_ADDR, LV_SAMPLE.
REQ-017 IDLE: timer loads POLL_PERIOD-1 on entry and decrements each clock; the FSM moves to EC_ADDR when timer==0 and enable==1; while enable==0 the timer holds at 0 once reached.
REQ-018 EC_ADDR: the FSM drives avm_address=3, chipselect=1, write_n=1 for one clock and then moves to EC_SAMPLE.
REQ-019 EC_SAMPLE: the FSM holds avm_address=3, chipselect=1, write_n=1 and samples avm_readdata[0] at the end of this clock; 1 -> EC_CLEAR, 0 -> LV_ADDR.
REQ-020 EC_CLEAR: the FSM drives avm_address=3, chipselect=1, write_n=0, writedata=0 for exactly one clock; in the same clock event_pulse=1 and event_count increments; next state LV_ADDR.
REQ-021 LV_ADDR then LV_SAMPLE: the FSM drives avm_address=0, chipselect=1, write_n=1; level<=avm_readdata[0] at the end of LV_SAMPLE; next state IDLE.
REQ-022 Outside active states the outputs SHALL be avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
REQ-023 Poll cycle length SHALL be POLL_PERIOD + 4 clocks without an event and POLL_PERIOD + 5 clocks with an event.
REQ-024 event_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-025 When count_clr and an increment coincide, clear SHALL win (count=0); event_pulse SHALL still assert.
REQ-026 Deasserting enable mid-transaction SHALL NOT abort it; the FSM completes to IDLE.
REQ-027 An edge arriving at the slave in the same clock as the EC_CLEAR write is lost (the slave clear has priority); this is accepted behaviour and SHALL NOT be compensated.
REQ-028 Multiple edges between polls SHALL count as one event.

Reset
REQ-029 Assertion of reset_n=0 SHALL immediately force IDLE, timer=POLL_PERIOD-1, event_count=0, event_pulse=0, level=0, busy=0, chipselect=0, write_n=1, address=0, writedata=0, including when asserted mid-transaction.
REQ-030 After reset release, the first EC_ADDR SHALL occur POLL_PERIOD clocks later if enable=1.

Structure
REQ-031 Shared package pio_poll_pkg SHALL hold the FSM state enum and constants ADDR_DATA=0 and ADDR_EDGE=3.
REQ-032 The poll interval counter SHALL be a sub-module pio_poll_timer (load, hold, zero flag).

Verification
REQ-033 Bench SHALL connect the block to the existing input-PIO slave; POLL_PERIOD=4, no edge -> chipselect pattern addr3,addr3,addr0,addr0 every 8 clocks, event_count stays 0.
REQ-034 Single 0->1 on in_port -> exactly one write to address 3, one event_pulse, event_count=1, level=1.
REQ-035 Three rising edges within one poll interval -> event_count increments by 1.
REQ-036 CNT_W=2 with 5 events -> event_count=3; count_clr coinciding with the 4th event -> event_count=0.
REQ-037 reset_n low during EC_CLEAR -> chipselect=0 and busy=0 in the same clock; first poll POLL_PERIOD clocks after release.
REQ-038 enable dropped during EC_SAMPLE -> transaction completes, no further polls until enable=1.
